alu_sequencer: RTL and testbench
================================

# alu_sequencer

Control sequencer that drives the datapath strobes for one register-to-register ALU instruction per request. Register-to-register ALU instructions write the result to register Rc; MUL and DIV write a 64-bit result to HI and LO. It moves Ra→Y and Rb→ALU, waits on the multi-cycle multiplier/divider when required, and steers Z back over the bus. It sits between the instruction decode logic and the Datapath, replacing hand-driven strobes.

## Interface
- NREGS, 16, number of general registers; width of the one-hot register selects
- MAX_WAIT, 40, maximum cycles spent in WAIT before a timeout
- OP_MUL, 5'b01110, multiply ALU op code
- OP_DIV, 5'b01111, divide ALU op code

- clk  in  1  system clock, rising edge
- Clear  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only in IDLE
- opcode  in  5  ALU op; values 5'b10000–5'b11111 are reserved
- ra, rb, rc  in  4 each  register indices
- alu_done  in  1  multi-cycle unit result valid in Z inputs
- alu_start  out  1  one-cycle pulse launching MUL/DIV; the unit latches its operands on this pulse
- Rout  out  NREGS  one-hot register-to-bus enable
- Rin  out  NREGS  one-hot register load
- Yin, Zin, LOin, HIin, Zlowout, Zhiout  out  1 each  datapath strobes
- IRout  out  5  ALU op select to the datapath
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse on a reserved opcode or a timeout

## Operation
- States: IDLE, S_A, S_B, WAIT, S_WB, S_LO, S_HI, S_DONE.
- IDLE + start + legal opcode → S_A. The sequencer latches opcode, ra, rb and rc on the same edge.
- IDLE + start + reserved opcode → no state change; err = 1 for the next cycle; no strobes.
- S_A: Rout[ra] = 1, Yin = 1 → S_B.
- S_B: Rout[rb] = 1, IRout = opcode.
  - Non-MUL/DIV: Zin = 1 → S_WB.
  - MUL/DIV: alu_start = 1 → WAIT.
- WAIT: IRout = opcode; wait counter increments each cycle.
  - alu_done = 1: Zin = 1 in that same cycle (Mealy, the only combinational output) → S_LO.
  - Counter reaches MAX_WAIT without alu_done: err = 1 → IDLE. No HI/LO write, no done.
- S_WB: Zlowout = 1, Rin[rc] = 1 → S_DONE.
- S_LO: Zlowout = 1, LOin = 1 → S_HI.
- S_HI: Zhiout = 1, HIin = 1 → S_DONE.
- S_DONE: done = 1 → IDLE.
- Invariants:
  - At most one bus driver per cycle (Rout bits, Zlowout, Zhiout).
  - Rout and Rin are always one-hot or zero.
  - Any strobe not listed for a state is 0.
- start while busy: ignored, not queued.
- Index out of range (≥ NREGS): the corresponding select is all zeros.

## Timing
- Reset (Clear high at a rising edge): state = IDLE, counter = 0. All outputs 0 from that edge, including mid-operation. An aborted operation produces no done and no err.
- All outputs except Zin-in-WAIT are Moore, decoded from the registered state.
- Latency, from the start edge (edge 0) to the done cycle:
  - Single-cycle op: S_A at cycle 1, S_B at 2, S_WB at 3, done at cycle 4.
  - MUL/DIV with alu_done in the k-th WAIT cycle (k ≥ 1): LO at cycle 3+k, HI at 4+k, done at 5+k.
- Timeout: err is asserted in WAIT cycle MAX_WAIT; IDLE follows on the next cycle.
- Back-to-back: start may be asserted in the cycle after S_DONE (IDLE). Minimum issue interval is 5 cycles.
- alu_done outside WAIT is ignored.

## Structure
- Shared package datapath_ctrl_pkg:
  - state enum
  - OP_MUL / OP_DIV constants
  - reserved-opcode range
  - NREGS default
- Sub-module onehot_dec (4-bit index → NREGS one-hot, with enable), instantiated for Rout and Rin.
- Remaining logic in one module: registered state, latched fields, wait counter, output decode.

## Test plan
- ADD opcode 5'b00011, ra=1, rb=2, rc=3, start at edge 0:
  - cycle 1: R1out + Yin
  - cycle 2: R2out + Zin, IRout=00011
  - cycle 3: Zlowout + R3in
  - cycle 4: done
  - err = 0 throughout
- MUL (01110), ra=1 (25), rb=2 (30), alu_done in WAIT cycle 5 with Z = 750:
  - alu_start at cycle 2
  - Zin at cycle 7
  - LOin + Zlowout at cycle 8
  - HIin + Zhiout at cycle 9
  - done at cycle 10
  - LO = 750, HI = 0
- DIV with alu_done never asserted: err pulses in WAIT cycle 40; no LOin/HIin; busy falls the next cycle.
- start with opcode 5'b10101: err at cycle 1; busy stays 0; every strobe stays 0.
- start re-asserted during S_B of a MUL: ignored; exactly one done pulse.
- Clear asserted in WAIT cycle 3: all outputs 0 after that edge; no done or err; a fresh ADD then completes in 4 cycles.

Source files
------------

// File: rtl/datapath_ctrl_pkg.sv
// rtl/datapath_ctrl_pkg.sv - shared types and constants for the ALU instruction sequencer
//
// Purpose: state encoding, MUL/DIV op codes, reserved-opcode range and
//          default sizing shared by the sequencer, its interface and bench.
// Ports:   none (package).
package datapath_ctrl_pkg;

   localparam int NREGS_DEF    = 16;
   localparam int MAX_WAIT_DEF = 40;

   localparam logic [4:0] OP_MUL     = 5'b01110;
   localparam logic [4:0] OP_DIV     = 5'b01111;
   // Every opcode from here up to 5'b11111 is reserved.
   localparam logic [4:0] OP_RSVD_LO = 5'b10000;

   typedef enum logic [2:0] {
      IDLE,
      S_A,
      S_B,
      WAIT,
      S_WB,
      S_LO,
      S_HI,
      S_DONE
   } state_t;

   function automatic logic is_reserved(input logic [4:0] op);
      return op >= OP_RSVD_LO;
   endfunction

   function automatic logic is_muldiv(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - decode/datapath-facing signal bundle of the ALU sequencer
//
// Purpose: groups the request inputs and datapath strobes of alu_sequencer.
// Ports:   master - decode/datapath side: drives start, opcode, ra, rb, rc,
//                   alu_done; observes strobes and status.
//          slave  - sequencer side: the reverse.
interface alu_sequencer_if
   import datapath_ctrl_pkg::*;
#(
   parameter int NREGS = NREGS_DEF
) ();

   logic             start;
   logic [4:0]       opcode;
   logic [3:0]       ra;
   logic [3:0]       rb;
   logic [3:0]       rc;
   logic             alu_done;

   logic             alu_start;
   logic [NREGS-1:0] Rout;
   logic [NREGS-1:0] Rin;
   logic             Yin;
   logic             Zin;
   logic             LOin;
   logic             HIin;
   logic             Zlowout;
   logic             Zhiout;
   logic [4:0]       IRout;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start, opcode, ra, rb, rc, alu_done,
      input  alu_start, Rout, Rin, Yin, Zin, LOin, HIin, Zlowout, Zhiout,
             IRout, busy, done, err
   );

   modport slave (
      input  start, opcode, ra, rb, rc, alu_done,
      output alu_start, Rout, Rin, Yin, Zin, LOin, HIin, Zlowout, Zhiout,
             IRout, busy, done, err
   );

endinterface

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - 4-bit index to N-bit one-hot decoder with enable
//
// Purpose: register-select decode; an index >= N yields all zeros.
// Ports:   idx_i    - register index
//          en_i     - decode enable; output is zero when low
//          onehot_o - one-hot select, N bits
module onehot_dec
   import datapath_ctrl_pkg::*;
#(
   parameter int N = NREGS_DEF
) (
   input  logic [3:0]   idx_i,
   input  logic         en_i,
   output logic [N-1:0] onehot_o
);

   always_comb begin
      onehot_o = '0;
      for (int i = 0; i < N; i++) begin
         if (en_i && ({28'd0, idx_i} == 32'(i))) begin
            onehot_o[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - strobe sequencer for one register-to-register ALU instruction
//
// Purpose: moves Ra->Y and Rb->ALU, waits for the MUL/DIV unit when needed,
//          then writes Z back to Rc (single-cycle ops) or LO/HI (MUL/DIV).
// Ports:   clk   - system clock, rising edge
//          Clear - synchronous active-high reset
//          bus   - alu_sequencer_if.slave: request in, datapath strobes out
module alu_sequencer
   import datapath_ctrl_pkg::*;
#(
   parameter int NREGS    = NREGS_DEF,
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input logic           clk,
   input logic           Clear,
   alu_sequencer_if.slave bus
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   state_t        state_q, state_d;
   logic [4:0]    op_q, op_d;
   logic [3:0]    ra_q, ra_d;
   logic [3:0]    rb_q, rb_d;
   logic [3:0]    rc_q, rc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;

   logic          muldiv;
   logic          timeout;
   logic          rout_en;
   logic [3:0]    rout_idx;

   assign muldiv  = is_muldiv(op_q);
   // cnt_q holds the 1-based index of the current WAIT cycle. The timeout
   // cycle wins over a late alu_done so that err stays a pure state decode.
   assign timeout = (state_q == WAIT) && (cnt_q == CW'(MAX_WAIT));

   always_ff @(posedge clk) begin
      if (Clear) begin
         state_q <= IDLE;
         op_q    <= '0;
         ra_q    <= '0;
         rb_q    <= '0;
         rc_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         rc_q    <= rc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      rc_d    = rc_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (is_reserved(bus.opcode)) begin
                  err_d = 1'b1;
               end else begin
                  state_d = S_A;
                  op_d    = bus.opcode;
                  ra_d    = bus.ra;
                  rb_d    = bus.rb;
                  rc_d    = bus.rc;
               end
            end
         end
         S_A: state_d = S_B;
         S_B: begin
            if (muldiv) begin
               state_d = WAIT;
               cnt_d   = CW'(1);
            end else begin
               state_d = S_WB;
            end
         end
         WAIT: begin
            if (timeout) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (bus.alu_done) begin
               state_d = S_LO;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WB:   state_d = S_DONE;
         S_LO:   state_d = S_HI;
         S_HI:   state_d = S_DONE;
         S_DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.alu_start = (state_q == S_B) && muldiv;
      bus.Yin       = (state_q == S_A);
      bus.Zin       = ((state_q == S_B) && !muldiv) ||
                      ((state_q == WAIT) && bus.alu_done && !timeout);
      bus.LOin      = (state_q == S_LO);
      bus.HIin      = (state_q == S_HI);
      bus.Zlowout   = (state_q == S_WB) || (state_q == S_LO);
      bus.Zhiout    = (state_q == S_HI);
      bus.IRout     = ((state_q == S_B) || (state_q == WAIT)) ? op_q : 5'd0;
      bus.busy      = (state_q != IDLE);
      bus.done      = (state_q == S_DONE);
      bus.err       = err_q || timeout;
   end

   assign rout_en  = (state_q == S_A) || (state_q == S_B);
   assign rout_idx = (state_q == S_A) ? ra_q : rb_q;

   onehot_dec #(.N(NREGS)) u_rout_dec (
      .idx_i    (rout_idx),
      .en_i     (rout_en),
      .onehot_o (bus.Rout)
   );

   onehot_dec #(.N(NREGS)) u_rin_dec (
      .idx_i    (rc_q),
      .en_i     (state_q == S_WB),
      .onehot_o (bus.Rin)
   );

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with a small datapath model
module tb_alu_sequencer;

   localparam int MAXW = 40;
   localparam logic [4:0] MUL = 5'b01110;
   localparam logic [4:0] DIV = 5'b01111;
   localparam logic [4:0] ADD = 5'b00011;

   typedef logic [46:0] ovec_t;

   logic clk = 1'b0;
   logic Clear;
   logic load;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   alu_sequencer_if #(.NREGS(16)) bus ();

   alu_sequencer #(.NREGS(16), .MAX_WAIT(MAXW)) dut (
      .clk   (clk),
      .Clear (Clear),
      .bus   (bus)
   );

   ovec_t act;
   assign act = {bus.alu_start, bus.Rout, bus.Rin, bus.Yin, bus.Zin, bus.LOin,
                 bus.HIin, bus.Zlowout, bus.Zhiout, bus.IRout, bus.busy,
                 bus.done, bus.err};

   function automatic logic [31:0] init_val(input int i);
      if (i == 1) return 32'd25;
      if (i == 2) return 32'd30;
      return 32'(i * 7 + 3);
   endfunction

   function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         5'b00011: return a + b;
         5'b00100: return a - b;
         5'b00101: return a & b;
         5'b00110: return a | b;
         default:  return a ^ b;
      endcase
   endfunction

   // Datapath model driven purely by the strobes.
   logic [31:0] rf [16];
   logic [31:0] y_m, lo_m, hi_m, opa_m, opb_m, bus_v;
   logic [63:0] z_m;

   always_comb begin
      bus_v = '0;
      for (int i = 0; i < 16; i++) if (bus.Rout[i]) bus_v = rf[i];
      if (bus.Zlowout) bus_v = z_m[31:0];
      if (bus.Zhiout)  bus_v = z_m[63:32];
   end

   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < 16; i++) rf[i] <= init_val(i);
         y_m <= '0; z_m <= '0; lo_m <= '0; hi_m <= '0; opa_m <= '0; opb_m <= '0;
      end else begin
         if (bus.Yin) y_m <= bus_v;
         if (bus.alu_start) begin
            opa_m <= y_m;
            opb_m <= bus_v;
         end
         if (bus.Zin) begin
            if (bus.IRout == MUL)      z_m <= {32'd0, opa_m} * {32'd0, opb_m};
            else if (bus.IRout == DIV) z_m <= (opb_m == 0) ? 64'd0 : {opa_m % opb_m, opa_m / opb_m};
            else                       z_m <= {32'd0, alu_f(bus.IRout, y_m, bus_v)};
         end
         for (int i = 0; i < 16; i++) if (bus.Rin[i]) rf[i] <= bus_v;
         if (bus.LOin) lo_m <= bus_v;
         if (bus.HIin) hi_m <= bus_v;
      end
   end

   // Shadow of architectural state, computed from the instruction semantics.
   logic [31:0] sh [16];
   logic [31:0] sh_lo, sh_hi;
   ovec_t exp_q [$];

   task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h", tag, actual, expected);
      end
   endtask

   function automatic ovec_t mk(input logic as, input logic [15:0] ro, input logic [15:0] ri,
                                input logic y, input logic z, input logic lo, input logic hi,
                                input logic zl, input logic zh, input logic [4:0] ir,
                                input logic bsy, input logic dn, input logic er);
      return {as, ro, ri, y, z, lo, hi, zl, zh, ir, bsy, dn, er};
   endfunction

   function automatic logic [15:0] oh(input logic [3:0] idx);
      logic [15:0] o;
      o = '0;
      o[idx] = 1'b1;
      return o;
   endfunction

   // k > 0: alu_done in WAIT cycle k; k < 0: alu_done never comes.
   // restart >= 0: start re-asserted in that cycle; clr >= 0: Clear in that cycle.
   task automatic run_op(input string nm, input logic [4:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] c, input int k,
                         input int restart, input int clr, input logic noise);
      logic        md;
      int          cyc;
      ovec_t       e;
      logic [63:0] prod;
      md = (op == MUL) || (op == DIV);
      exp_q.push_back('0);
      exp_q.push_back(mk(0, oh(a), 0, 1, 0, 0, 0, 0, 0, 5'd0, 1, 0, 0));
      if (!md) begin
         exp_q.push_back(mk(0, oh(b), 0, 0, 1, 0, 0, 0, 0, op, 1, 0, 0));
         exp_q.push_back(mk(0, 0, oh(c), 0, 0, 0, 0, 1, 0, 5'd0, 1, 0, 0));
         exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 1, 1, 0));
      end else begin
         exp_q.push_back(mk(1, oh(b), 0, 0, 0, 0, 0, 0, 0, op, 1, 0, 0));
         if (k > 0) begin
            for (int w = 1; w <= k; w++)
               exp_q.push_back(mk(0, 0, 0, 0, w == k, 0, 0, 0, 0, op, 1, 0, 0));
            exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 5'd0, 1, 0, 0));
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 5'd0, 1, 0, 0));
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 1, 1, 0));
         end else begin
            for (int w = 1; w <= MAXW; w++)
               exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, op, 1, 0, w == MAXW));
         end
      end
      if (clr >= 0) begin
         while (exp_q.size() > clr + 1) e = exp_q.pop_back();
         exp_q.push_back('0);
         exp_q.push_back('0);
      end else if (!md) begin
         sh[c] = alu_f(op, sh[a], sh[b]);
      end else if (k > 0) begin
         if (op == MUL) prod = {32'd0, sh[a]} * {32'd0, sh[b]};
         else           prod = {sh[a] % sh[b], sh[a] / sh[b]};
         sh_lo = prod[31:0];
         sh_hi = prod[63:32];
      end

      cyc = 0;
      while (exp_q.size() != 0) begin
         bus.start    = (cyc == 0) || (cyc == restart);
         bus.opcode   = op;
         bus.ra       = a;
         bus.rb       = b;
         bus.rc       = c;
         bus.alu_done = md ? (k > 0 && cyc == 2 + k) : noise;
         Clear        = (cyc == clr);
         @(negedge clk);
         e = exp_q.pop_front();
         check($sformatf("%s_c%0d", nm, cyc), 64'(act), 64'(e));
         @(posedge clk);
         #1;
         cyc++;
      end
      bus.start    = 1'b0;
      bus.alu_done = 1'b0;
      Clear        = 1'b0;
      check($sformatf("%s_rc", nm), 64'(rf[c]), 64'(sh[c]));
      check($sformatf("%s_lo", nm), 64'(lo_m), 64'(sh_lo));
      check($sformatf("%s_hi", nm), 64'(hi_m), 64'(sh_hi));
   endtask

   initial begin
      logic [4:0] ops [4];
      ops[0] = 5'b00011; ops[1] = 5'b00100; ops[2] = 5'b00101; ops[3] = 5'b00110;
      for (int i = 0; i < 16; i++) sh[i] = init_val(i);
      sh_lo = '0;
      sh_hi = '0;
      Clear = 1'b1;
      load  = 1'b1;
      bus.start = 1'b0; bus.opcode = '0; bus.ra = '0; bus.rb = '0; bus.rc = '0; bus.alu_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      Clear = 1'b0;
      load  = 1'b0;
      @(negedge clk);
      check("reset", 64'(act), 64'd0);
      @(posedge clk);
      #1;

      run_op("add", ADD, 4'd1, 4'd2, 4'd3, 0, -1, -1, 1'b0);
      run_op("mul", MUL, 4'd1, 4'd2, 4'd4, 5, -1, -1, 1'b0);
      check("mul_lo750", 64'(lo_m), 64'd750);
      run_op("div_to", DIV, 4'd5, 4'd2, 4'd0, -1, -1, -1, 1'b0);

      bus.start  = 1'b1;
      bus.opcode = 5'b10101;
      @(negedge clk);
      check("rsv_c0", 64'(act), 64'd0);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(negedge clk);
      check("rsv_c1", 64'(act), 64'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 1)));
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rsv_c2", 64'(act), 64'd0);
      @(posedge clk);
      #1;

      run_op("mul_rs", MUL, 4'd1, 4'd2, 4'd0, 3, 2, -1, 1'b0);
      run_op("div", DIV, 4'd5, 4'd2, 4'd0, 2, -1, -1, 1'b0);
      run_op("clr", MUL, 4'd1, 4'd2, 4'd0, -1, -1, 5, 1'b0);
      run_op("add2", ADD, 4'd3, 4'd3, 4'd6, 0, -1, -1, 1'b1);
      run_op("mul1", MUL, 4'd6, 4'd7, 4'd0, 1, -1, -1, 1'b0);
      for (int t = 0; t < 4; t++) begin
         run_op($sformatf("rnd%0d", t), ops[t],
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 0, -1, -1, 1'($urandom_range(0, 1)));
      end

      @(negedge clk);
      check("final_idle", 64'(act), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
